// File: rtl/irda_mir_rx_bitsync.sv
// MIR receive bit synchroniser: recovers bit-cell timing from raw IR pulses and emits RZI-decoded bits.
// Optional pulse-width qualification when IRDA_MIR_RX_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module irda_mir_rx_bitsync #(
  parameter int BIT_CLKS  = 16,
  parameter int CNT_W     = 4,
  parameter int P_NOM     = 4,
  parameter int LOSS_BITS = 32,
  parameter int MIN_PW    = 2
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic rx_pad_i,
  input  logic mir_rx_en,
  output logic rx_o,
  output logic mir_rxbit_enable,
  output logic mir_rx_locked
);

`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
  localparam int P_CMP  = P_NOM + MIN_PW - 1;
  localparam int P_SNAP = P_NOM + MIN_PW;
  localparam int SYNC_W = 2;
`else
  localparam int P_CMP  = P_NOM;
  localparam int P_SNAP = P_NOM + 1;
  localparam int SYNC_W = 3;
`endif

  localparam logic [CNT_W-1:0] PH_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] PH_CMP    = CNT_W'(P_CMP);
  localparam logic [CNT_W-1:0] PH_SNAP   = CNT_W'(P_SNAP);
  localparam logic [CNT_W-1:0] PH_MINGAP = CNT_W'(BIT_CLKS - 2);
  localparam logic [7:0]       MISS_LAST = 8'(LOSS_BITS - 1);

  if (BIT_CLKS < 8 || (1 << CNT_W) < BIT_CLKS || P_NOM < 1 || P_NOM > BIT_CLKS - 2 ||
      LOSS_BITS < 2 || LOSS_BITS > 255 || MIN_PW < 1 || MIN_PW > 255 ||
      P_SNAP > BIT_CLKS - 1) begin : g_bad_param
    $error("irda_mir_rx_bitsync: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, HUNT, TRACK} state_t;

  state_t             state_q, state_d;
  logic [SYNC_W-1:0]  sync_q, sync_d;
  logic [CNT_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [7:0]         miss_q, miss_d;
  logic               flag_q, flag_d;
  logic               stall_q, stall_d;
  logic               skip_q, skip_d;
  logic               rxh_q, rxh_d;
  logic               rx_s, rise, strobe, cell_pulse;

  assign sync_d = {sync_q[SYNC_W-2:0], rx_pad_i};
  assign rx_s   = sync_q[1];

`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
  logic [7:0] run_q, run_d;
  // run_q counts earlier consecutive high cycles, so the qualified edge fires on the MIN_PW-th high cycle.
  assign run_d = rx_s ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : 8'd0;
  assign rise  = rx_s && (run_q == 8'(MIN_PW - 1));
`else
  assign rise  = rx_s & ~sync_q[2];
`endif

  assign cell_pulse       = flag_q | rise;
  assign mir_rxbit_enable = strobe;
  assign rx_o             = strobe ? ~cell_pulse : rxh_q;
  assign mir_rx_locked    = (state_q == TRACK);

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    stall_d = stall_q;
    skip_d  = skip_q;
    miss_d  = miss_q;
    rxh_d   = rxh_q;
    gap_d   = (gap_q == PH_LAST) ? gap_q : gap_q + 1'b1;
    ph_d    = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    strobe  = 1'b0;
    if (!mir_rx_en) begin
      state_d = IDLE;
      ph_d    = '0;
      flag_d  = 1'b0;
      stall_d = 1'b0;
      skip_d  = 1'b0;
      miss_d  = '0;
      rxh_d   = 1'b1;
      gap_d   = PH_LAST;
    end else begin
      // A freshly snapped phase can reach the cell end early; that strobe is held off and the cell merges.
      strobe = (state_q != IDLE) && (ph_q == PH_LAST) && (gap_q >= PH_MINGAP);
      if (strobe) begin
        rxh_d  = ~cell_pulse;
        flag_d = 1'b0;
        gap_d  = '0;
      end else if (rise) begin
        flag_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          state_d = HUNT;
          ph_d    = '0;
        end
        HUNT: begin
          if (rise) begin
            state_d = TRACK;
            ph_d    = PH_SNAP;
            flag_d  = 1'b1;
            stall_d = 1'b0;
            skip_d  = 1'b0;
            miss_d  = '0;
          end
        end
        TRACK: begin
          if (rise && !flag_q) begin
            if (ph_q > PH_CMP)      stall_d = 1'b1;
            else if (ph_q < PH_CMP) skip_d  = 1'b1;
          end
          if (ph_q == PH_LAST) begin
            if (skip_q) begin
              ph_d   = CNT_W'(1);
              skip_d = 1'b0;
            end
          end else if (ph_q == '0 && stall_q) begin
            ph_d    = '0;
            stall_d = 1'b0;
          end
          if (strobe) begin
            if (cell_pulse) begin
              miss_d = '0;
            end else if (miss_q == MISS_LAST) begin
              state_d = HUNT;
              miss_d  = '0;
              stall_d = 1'b0;
              skip_d  = 1'b0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ph_q    <= '0;
      gap_q   <= PH_LAST;
      miss_q  <= '0;
      flag_q  <= 1'b0;
      stall_q <= 1'b0;
      skip_q  <= 1'b0;
      rxh_q   <= 1'b1;
`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
      run_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ph_q    <= ph_d;
      gap_q   <= gap_d;
      miss_q  <= miss_d;
      flag_q  <= flag_d;
      stall_q <= stall_d;
      skip_q  <= skip_d;
      rxh_q   <= rxh_d;
`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
      run_q   <= run_d;
`endif
    end
  end

endmodule
